serial_binadd: RTL and testbench
================================

// Module: serial_binadd
// PURPOSE
//   Bit-serial, LSB-first WIDTH-bit adder with a start/done handshake.
//   It is the inverse of the binsub subtractor: fed binsub's difference s
//   and subtrahend b, it rebuilds the minuend (sum == a mod 2^WIDTH).
//   It is used in the self-checking datapath as the reconstruction stage
//   after the subtractor. One full-adder slice is reused over WIDTH cycles.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (legal range 2..16)
// PORTS
//   clk    in   1      single clock; all state on rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only when busy==0
//   s      in   WIDTH  first operand (difference from binsub)
//   b      in   WIDTH  second operand (subtrahend)
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse; sum/cout valid from this cycle
//   sum    out  WIDTH  (s + b) mod 2^WIDTH, registered
//   cout   out  1      carry out of bit WIDTH-1, registered
// BEHAVIOUR
//   - Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, count=0.
//   - FSM states IDLE, SHIFT, DONE.
//   - IDLE and DONE accept start.
//   - On start=1 at edge k:
//     - load s and b into shift regs; carry<=0; count<=0; go to SHIFT.
//   - SHIFT, one bit per edge:
//     - bit = sA[0]^sB[0]^carry; carry <= majority(sA[0], sB[0], carry).
//     - shift bit into the MSB of the result reg; shift sA and sB right.
//     - count++.
//     - When count reaches WIDTH-1, that edge writes final sum and cout
//       into the output regs and the next state is DONE.
//   - Timing: SHIFT occupies edges k+1..k+WIDTH.
//     - busy=1 during those cycles.
//     - done=1 for exactly the cycle after edge k+WIDTH.
//     - start-to-done latency = WIDTH+1 cycles.
//   - DONE lasts one cycle. Next state is SHIFT if start=1 (back-to-back
//     with a new operand load), else IDLE.
//   - start while busy=1 is ignored; s/b changes during SHIFT have no
//     effect (operands are captured at start).
//   - sum/cout hold the previous result during SHIFT and change only on
//     the edge that enters DONE; they hold until the next completion.
//   - Arithmetic is unsigned modulo 2^WIDTH; wrap-around sets cout=1.
//   - rst=1 at any time, including mid-SHIFT: the operation is abandoned
//     at the next edge, all outputs return to reset values, and no done
//     pulse is produced.
//   - rst and start high on the same edge: rst wins.
// TESTING (WIDTH=4)
//   1. s=4'b1110, b=4'b0011, start pulse -> busy 4 cycles;
//      done at cycle 5; sum=4'b0001, cout=1.
//   2. s=4'b1010, b=4'b1011 -> sum=4'b0101, cout=1;
//      then s=4'b0000, b=4'b0011 -> sum=4'b0011, cout=0.
//   3. s=4'b1111, b=4'b1101, start held high through done
//      -> sum=4'b1100, cout=1; immediate restart from DONE; busy
//      reasserts with no idle gap; second done exactly 5 cycles later.
//   4. Start s=4'b0110, b=4'b0011, then pulse start with s=4'b1111 on
//      cycle 2 -> second start ignored; sum=4'b1001, cout=0.
//   5. Start s=4'b1111, b=4'b0001, assert rst on cycle 2
//      -> next edge busy=0, sum=0, cout=0; no done pulse.
//   6. Exhaustive 256-pair sweep: sum == (s+b)%16, cout == (s+b)>15.
//      Also check sum == a when s = (a-b)%16.

Source files
------------

// File: rtl/serial_binadd_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_binadd_if
//  Description : Start/done handshake and operand/result bundle for serial_binadd.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_binadd_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, s, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, s, b,
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_binadd.sv
`default_nettype none
// ============================================================================
//  Module      : serial_binadd
//  Description : Bit-serial LSB-first adder; one full-adder slice over WIDTH cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_binadd #(
    parameter int WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_binadd_if.slave     bus
);
    localparam int         c_CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-2:0] r_res;
    logic [c_CW-1:0]  r_count;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_bit;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_shift;
    logic             w_last;

    assign w_bit        = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_carry_next = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
    // New bit enters at the MSB; on the final slice this is the complete sum.
    assign w_shift      = {w_bit, r_res};
    assign w_last       = (r_count == c_CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_sa    <= bus.s;
                        r_sb    <= bus.b;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_state <= c_ST_SHIFT;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SHIFT: begin
                    r_carry <= w_carry_next;
                    r_res   <= w_shift[WIDTH-1:1];
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_count <= r_count + c_CW'(1);
                    if (w_last) begin
                        r_sum   <= w_shift;
                        r_cout  <= w_carry_next;
                        r_state <= c_ST_DONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == c_ST_SHIFT);
    assign bus.done = (r_state == c_ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_binadd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_binadd
//  Description : Self-checking bench for serial_binadd (WIDTH=4) against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_binadd;
    localparam int c_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_binadd_if #(.WIDTH(c_W)) bus ();
    serial_binadd #(.WIDTH(c_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one addition and waits for done; s/b are scrambled while it runs.
    task automatic do_add(input logic [3:0] s, input logic [3:0] b, output int lat,
                          output int busy_cnt, output logic [3:0] osum, output logic ocout);
        bus.start = 1'b1; bus.s = s; bus.b = b;
        tick();
        bus.start = 1'b0;
        bus.s = 4'($urandom); bus.b = 4'($urandom);
        lat = 1; busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        osum = bus.sum; ocout = bus.cout;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.s = 4'hF; bus.b = 4'hF;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.sum !== 4'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
        bus.start = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc; logic [3:0] sm; logic co;
        do_add(4'b1110, 4'b0011, lat, bc, sm, co);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
        checks++; if (sm !== 4'b0001) begin errors++; $display("FAIL basic_sum got=%b exp=0001", sm); end
        checks++; if (co !== 1'b1) begin errors++; $display("FAIL basic_cout got=%b exp=1", co); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
        checks++; if (bus.sum !== 4'b0001) begin errors++; $display("FAIL basic_sum_hold got=%b exp=0001", bus.sum); end
    endtask

    task automatic test_sequence();
        int lat, bc; logic [3:0] sm; logic co;
        do_add(4'b1010, 4'b1011, lat, bc, sm, co);
        checks++; if (sm !== 4'b0101 || co !== 1'b1) begin errors++; $display("FAIL seq1 got=%b/%b exp=0101/1", sm, co); end
        tick();
        bus.start = 1'b1; bus.s = 4'b0000; bus.b = 4'b0011;
        tick();
        bus.start = 1'b0;
        // Previous result must hold while the next addition is in flight.
        checks++; if (bus.sum !== 4'b0101 || bus.cout !== 1'b1) begin errors++; $display("FAIL seq_hold got=%b/%b exp=0101/1", bus.sum, bus.cout); end
        lat = 1;
        while (!bus.done && lat < 40) begin tick(); lat++; end
        checks++; if (bus.sum !== 4'b0011 || bus.cout !== 1'b0 || lat !== 5) begin
            errors++; $display("FAIL seq2 got=%b/%b lat=%0d exp=0011/0 lat=5", bus.sum, bus.cout, lat); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        bus.start = 1'b1; bus.s = 4'b1111; bus.b = 4'b1101;
        n = 0;
        do begin tick(); n++; end while (!bus.done && n < 40);
        checks++; if (bus.sum !== 4'b1100 || bus.cout !== 1'b1 || n !== 5) begin
            errors++; $display("FAIL b2b_first got=%b/%b lat=%0d exp=1100/1 lat=5", bus.sum, bus.cout, n); end
        bus.s = 4'b0011; bus.b = 4'b0100;
        tick();
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL b2b_no_gap got busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done); end
        n = 1;
        while (!bus.done && n < 40) begin tick(); n++; end
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=5", n); end
        checks++; if (bus.sum !== 4'b0111 || bus.cout !== 1'b0) begin
            errors++; $display("FAIL b2b_second got=%b/%b exp=0111/0", bus.sum, bus.cout); end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_ignore_start();
        int n;
        bus.start = 1'b1; bus.s = 4'b0110; bus.b = 4'b0011;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.s = 4'b1111;
        tick();
        bus.start = 1'b0;
        n = 3;
        while (!bus.done && n < 40) begin tick(); n++; end
        checks++; if (bus.sum !== 4'b1001 || bus.cout !== 1'b0 || n !== 5) begin
            errors++; $display("FAIL ignore_start got=%b/%b lat=%0d exp=1001/0 lat=5", bus.sum, bus.cout, n); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.start = 1'b1; bus.s = 4'b1111; bus.b = 4'b0001;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 4'h0 || bus.cout !== 1'b0) begin
            errors++; $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b exp 0/0/0/0", bus.busy, bus.done, bus.sum, bus.cout); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (bus.done) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done got=%b exp=0", seen); end
    endtask

    task automatic test_rst_vs_start();
        rst = 1'b1; bus.start = 1'b1; bus.s = 4'h5; bus.b = 4'h5;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_wins got busy=%b exp=0", bus.busy); end
        tick();
    endtask

    // Exhaustive: drive s=(a-b) mod 16, expect the adder to rebuild a.
    task automatic test_sweep();
        int lat, bc; logic [3:0] sm; logic co;
        int s_i, exp_sum, exp_cout;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                s_i      = (a - b + 16) % 16;
                exp_sum  = (s_i + b) % 16;
                exp_cout = ((s_i + b) > 15) ? 1 : 0;
                do_add(4'(s_i), 4'(b), lat, bc, sm, co);
                checks++;
                if (sm !== 4'(exp_sum) || co !== 1'(exp_cout) || sm !== 4'(a) || lat !== 5) begin
                    errors++;
                    $display("FAIL sweep s=%h b=%h got=%h/%b lat=%0d exp=%h/%0d lat=5", s_i, b, sm, co, lat, exp_sum, exp_cout);
                end
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.s = '0; bus.b = '0;
        test_reset();
        test_basic();
        test_sequence();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_rst_vs_start();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
